// File: rtl/dataram_lat.sv
// dataram_lat -- latency-modelled line-wide data memory for the pipeline's
// memory stage.
//
// A request is accepted on a rising edge where req & ready. The operands
// are captured at that edge, so the requester may change them afterwards.
// The access then waits LATENCY cycles in WAIT. It is performed on the edge
// that enters RESP, and complete is high for that single RESP cycle. A new
// request may be accepted in RESP, which gives back-to-back accesses.
//
// Ports:
//   clk      in   single clock, rising edge
//   rst      in   synchronous active-high reset
//   req      in   access request, sampled only while ready=1
//   we       in   1 = write, 0 = read (captured at accept)
//   addr     in   line address (captured at accept)
//   offset   in   word within the line for writes (captured at accept)
//   byte_en  in   byte lanes of din to write (captured at accept)
//   din      in   32-bit write data (captured at accept)
//   ready    out  a request can be accepted this cycle
//   complete out  one-cycle pulse when the access has finished
//   dout     out  full line from the last completed read, held otherwise
module dataram_lat #(
  parameter int ADDR_W  = 8,
  parameter int WORDS   = 4,
  parameter int LATENCY = 20
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       req,
  input  logic                                       we,
  input  logic [ADDR_W-1:0]                          addr,
  input  logic [((WORDS > 1) ? $clog2(WORDS) : 1)-1:0] offset,
  input  logic [3:0]                                 byte_en,
  input  logic [31:0]                                din,
  output logic                                       ready,
  output logic                                       complete,
  output logic [32*WORDS-1:0]                        dout
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int OFF_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int CNT_W = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
  // The last WAIT count. It is unused when LATENCY=0 because WAIT is never entered.
  localparam logic [CNT_W-1:0] CNT_LAST = (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;

  // Operand holding registers, loaded on every accept.
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [OFF_W-1:0]  r_off;
  logic [3:0]        r_be;
  logic [31:0]       r_din;

  // Operands of the access currently being performed.
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [OFF_W-1:0]  w_off;
  logic [3:0]        w_be;
  logic [31:0]       w_din;

  logic w_accept;
  logic w_do_access;

  assign ready    = (r_state != S_WAIT);
  assign complete = (r_state == S_RESP);

  // req is ignored while reset is asserted.
  assign w_accept = req & ready & ~rst;

  // With no latency the access happens on the accept edge itself, so it uses
  // the live inputs. Otherwise it uses the operands captured at accept.
  assign w_we   = (LATENCY == 0) ? we      : r_we;
  assign w_addr = (LATENCY == 0) ? addr    : r_addr;
  assign w_off  = (LATENCY == 0) ? offset  : r_off;
  assign w_be   = (LATENCY == 0) ? byte_en : r_be;
  assign w_din  = (LATENCY == 0) ? din     : r_din;

  // Reset on the final WAIT edge drops the access, so an in-flight write
  // never reaches memory.
  assign w_do_access = ~rst & ((LATENCY == 0) ? w_accept
                                              : ((r_state == S_WAIT) && (r_cnt == CNT_LAST)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      S_IDLE, S_RESP: begin
        if (w_accept) begin
          w_cnt_next   = '0;
          w_state_next = (LATENCY == 0) ? S_RESP : S_WAIT;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_WAIT: begin
        // Exit one count early so that the counter never needs to hold LATENCY.
        if (r_cnt == CNT_LAST) begin
          w_state_next = S_RESP;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_we   <= we;
      r_addr <= addr;
      r_off  <= offset;
      r_be   <= byte_en;
      r_din  <= din;
    end
  end

  // Storage is split into one byte-wide array per (word, lane). A byte-enabled
  // word write then touches only the selected arrays, and no read-modify-write
  // of the full line is needed. Each array has its own registered read port,
  // which feeds its slice of dout.
  for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
    for (genvar gb = 0; gb < 4; gb++) begin : g_lane
      logic [7:0] r_mem [DEPTH];
      logic [7:0] r_q;
      logic       w_wr;

      assign w_wr = w_do_access & w_we & w_be[gb] &
                    ((WORDS == 1) || (w_off == OFF_W'(gi)));

      always_ff @(posedge clk) begin
        if (w_wr) begin
          r_mem[w_addr] <= w_din[8*gb +: 8];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          r_q <= '0;
        end else if (w_do_access && !w_we) begin
          r_q <= r_mem[w_addr];
        end
      end

      assign dout[32*gi + 8*gb +: 8] = r_q;
    end
  end

endmodule

// File: tb/tb_dataram_lat.sv
// tb_dataram_lat -- scoreboard bench for dataram_lat.
// u0: ADDR_W=8, WORDS=4, LATENCY=20. u1: ADDR_W=4, WORDS=4, LATENCY=0.
// The two instances share the operand inputs and have separate req lines.
// A reference line store computes the expected line and the completion cycle
// of each accepted request. Per-instance monitors pop these on complete.
module tb_dataram_lat;

  localparam int LAT0 = 20;
  localparam int LAT1 = 0;

  typedef struct {
    logic [127:0] data;
    int           cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0 = 1'b0;
  logic         req1 = 1'b0;
  logic         we_i = 1'b0;
  logic [7:0]   addr_i = '0;
  logic [1:0]   off_i = '0;
  logic [3:0]   be_i = '0;
  logic [31:0]  din_i = '0;
  logic         ready0, complete0, ready1, complete1;
  logic [127:0] dout0, dout1;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  logic [127:0] m0 [256];
  logic [127:0] m1 [16];
  logic [127:0] last0 = '0;
  logic [127:0] last1 = '0;
  exp_t q0[$];
  exp_t q1[$];

  dataram_lat #(.ADDR_W(8), .WORDS(4), .LATENCY(LAT0)) u0 (
    .clk(clk), .rst(rst), .req(req0), .we(we_i), .addr(addr_i), .offset(off_i),
    .byte_en(be_i), .din(din_i), .ready(ready0), .complete(complete0), .dout(dout0)
  );

  dataram_lat #(.ADDR_W(4), .WORDS(4), .LATENCY(LAT1)) u1 (
    .clk(clk), .rst(rst), .req(req1), .we(we_i), .addr(addr_i[3:0]), .offset(off_i),
    .byte_en(be_i), .din(din_i), .ready(ready1), .complete(complete1), .dout(dout1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  // Reference behaviour. A write merges the enabled bytes into the chosen word
  // and leaves dout as the last read line. A read returns the whole line.
  function automatic logic [127:0] model_apply(input int d, input logic w, input logic [7:0] a,
                                               input logic [1:0] o, input logic [3:0] b,
                                               input logic [31:0] dt);
    logic [127:0] line;
    line = (d == 0) ? m0[a] : m1[a[3:0]];
    if (w) begin
      for (int i = 0; i < 4; i++)
        if (b[i]) line[32*int'(o) + 8*i +: 8] = dt[8*i +: 8];
      if (d == 0) m0[a] = line; else m1[a[3:0]] = line;
      return (d == 0) ? last0 : last1;
    end
    if (d == 0) last0 = line; else last1 = line;
    return line;
  endfunction

  // Called in the cycle before the accept edge (cycle 0). complete is due in cycle LATENCY+1.
  task automatic push_exp(input int d, input logic [127:0] data);
    exp_t e;
    e.data = data;
    e.cyc  = cyc + ((d == 0) ? LAT0 : LAT1) + 1;
    if (d == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic issue(input int d, input logic w, input logic [7:0] a, input logic [1:0] o,
                       input logic [3:0] b, input logic [31:0] dt);
    int guard;
    we_i = w; addr_i = a; off_i = o; be_i = b; din_i = dt;
    if (d == 0) req0 = 1'b1; else req1 = 1'b1;
    guard = 0;
    forever begin
      @(negedge clk);
      if ((d == 0) ? ready0 : ready1) break;
      guard++;
      if (guard > 100) begin
        n_cmp++; n_err++;
        $display("FAIL issue_timeout: dut%0d ready stayed 0, required 1", d);
        req0 = 1'b0; req1 = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    push_exp(d, model_apply(d, w, a, o, b, dt));
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic drain(input int d);
    int guard;
    guard = 0;
    while (((d == 0) ? q0.size() : q1.size()) != 0) begin
      @(negedge clk);
      guard++;
      if (guard > 100) begin
        n_cmp++; n_err++;
        $display("FAIL drain_timeout: dut%0d has %0d pending, required 0", d,
                 (d == 0) ? q0.size() : q1.size());
        q0.delete(); q1.delete();
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  // Monitors: every complete pulse must match the next expected response.
  always @(negedge clk) begin
    if (!rst && complete0) begin
      if (q0.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL spurious_complete0: got complete=1 at cycle %0d, required 0", cyc);
      end else begin
        exp_t e;
        e = q0.pop_front();
        $display("[%0d] dut0 complete dout=%h", cyc, dout0);
        check("latency0", 128'(cyc), 128'(e.cyc));
        check("dout0", dout0, e.data);
        check("ready_resp0", 128'(ready0), 128'(1));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && complete1) begin
      if (q1.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL spurious_complete1: got complete=1 at cycle %0d, required 0", cyc);
      end else begin
        exp_t e;
        e = q1.pop_front();
        $display("[%0d] dut1 complete dout=%h", cyc, dout1);
        check("latency1", 128'(cyc), 128'(e.cyc));
        check("dout1", dout1, e.data);
        check("ready_resp1", 128'(ready1), 128'(1));
      end
    end
  end

  initial begin
    #500000;
    n_cmp++; n_err++;
    $display("FAIL watchdog: simulation still running at cycle %0d", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    logic [31:0] v;
    logic [7:0]  a;
    int          c0;
    int          n_wait;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready0", 128'(ready0), 128'(1));
    check("rst_complete0", 128'(complete0), 128'(0));
    check("rst_dout0", dout0, 128'(0));
    check("rst_ready1", 128'(ready1), 128'(1));
    check("rst_complete1", 128'(complete1), 128'(0));
    check("rst_dout1", dout1, 128'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    // Fill lines 0..7 of u0 so that every later read has defined data.
    for (int l = 0; l < 8; l++)
      for (int w = 0; w < 4; w++)
        issue(0, 1'b1, 8'(l), 2'(w), 4'hF, $urandom);

    // Basic write and read.
    issue(0, 1'b1, 8'd5, 2'd2, 4'hF, 32'hDEADBEEF);
    issue(0, 1'b0, 8'd5, 2'd0, 4'h0, 32'h0);
    drain(0);
    check("basic_word2", 128'(dout0[95:64]), 128'(32'hDEADBEEF));

    // Byte enables.
    issue(0, 1'b1, 8'd3, 2'd0, 4'hF, 32'h11223344);
    issue(0, 1'b1, 8'd3, 2'd0, 4'b0101, 32'hAABBCCDD);
    issue(0, 1'b0, 8'd3, 2'd0, 4'h0, 32'h0);
    drain(0);
    check("byte_en_word0", 128'(dout0[31:0]), 128'(32'h11BB33DD));

    // Operand capture. The operands change after accept while req stays high.
    v = $urandom;
    we_i = 1'b1; addr_i = 8'd2; off_i = 2'd1; be_i = 4'hF; din_i = v; req0 = 1'b1;
    @(negedge clk);
    c0 = cyc;
    push_exp(0, model_apply(0, 1'b1, 8'd2, 2'd1, 4'hF, v));
    @(posedge clk); #1;
    we_i = 1'b0; addr_i = 8'd6; din_i = $urandom; be_i = 4'h0;
    n_wait = 0;
    forever begin
      @(negedge clk);
      if (ready0 || n_wait > 100) break;
      n_wait++;
      @(posedge clk); #1;
    end
    check("wait_cycles_ready_low", 128'(n_wait), 128'(LAT0));
    check("accept_in_resp", 128'(cyc), 128'(c0 + LAT0 + 1));
    push_exp(0, model_apply(0, 1'b0, 8'd6, 2'd0, 4'h0, 32'h0));
    @(posedge clk); #1;
    req0 = 1'b0;
    issue(0, 1'b0, 8'd2, 2'd0, 4'h0, 32'h0);
    drain(0);
    check("capture_word1", 128'(dout0[63:32]), 128'(v));

    // Random traffic on u0.
    for (int i = 0; i < 40; i++) begin
      a = 8'($urandom_range(0, 7));
      issue(0, 1'($urandom), a, 2'($urandom), 4'($urandom), $urandom);
    end
    issue(0, 1'b0, 8'd1, 2'd0, 4'h0, 32'h0);
    drain(0);

    // Reset during WAIT of a write to line 7.
    we_i = 1'b1; addr_i = 8'd7; off_i = 2'd0; be_i = 4'hF; din_i = ~m0[7][31:0]; req0 = 1'b1;
    @(negedge clk);
    check("rstw_accept_ready", 128'(ready0), 128'(1));
    @(posedge clk); #1;
    req0 = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    req0 = 1'b1;
    @(negedge clk);
    check("rstw_ready_in_wait", 128'(ready0), 128'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    req0 = 1'b0;
    last0 = '0;
    @(negedge clk);
    check("rstw_ready", 128'(ready0), 128'(1));
    check("rstw_complete", 128'(complete0), 128'(0));
    check("rstw_dout", dout0, 128'(0));
    repeat (30) @(posedge clk);
    #1;
    issue(0, 1'b0, 8'd7, 2'd0, 4'h0, 32'h0);
    drain(0);

    // u1 (LATENCY=0): fill all 16 lines.
    for (int l = 0; l < 16; l++)
      for (int w = 0; w < 4; w++)
        issue(1, 1'b1, 8'(l), 2'(w), 4'hF, $urandom);
    // Alternate writes and reads of lines 0..3, one per cycle.
    for (int i = 0; i < 16; i++) begin
      a = 8'((i / 2) % 4);
      issue(1, (i % 2) == 0, a, 2'($urandom), 4'($urandom), $urandom);
    end
    // Depth check: lines 0 and 15 must not alias.
    issue(1, 1'b1, 8'd0, 2'd3, 4'hF, 32'h0000_A000);
    issue(1, 1'b1, 8'd15, 2'd3, 4'hF, 32'h0000_F015);
    issue(1, 1'b0, 8'd0, 2'd0, 4'h0, 32'h0);
    issue(1, 1'b0, 8'd15, 2'd0, 4'h0, 32'h0);
    drain(1);
    check("wrap_line15_word3", 128'(dout1[127:96]), 128'(32'h0000_F015));
    for (int i = 0; i < 40; i++) begin
      a = 8'($urandom_range(0, 15));
      issue(1, 1'($urandom), a, 2'($urandom), 4'($urandom), $urandom);
    end
    drain(1);
    repeat (5) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dataram_lat.md
# dataram_lat

Parametrised, latency-modelled data memory for the MIPS pipeline's memory stage. It replaces the fixed 128-bit line store with a configurable line width, depth and latency. It adds a request/ready handshake with operands captured at accept, per-byte write enables and a one-cycle completion pulse. The pipeline stalls the memory stage until `complete` is seen.

## Interface
Parameters:
- `ADDR_W`, 8: line-address width; depth = 2**ADDR_W lines.
- `WORDS`, 4: 32-bit words per line (power of two, ≥1); line width = 32*WORDS.
- `LATENCY`, 20: artificial wait cycles, ≥0.

Ports:
- `clk`, in, 1: single clock; all state changes on its rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `req`, in, 1: access request; sampled only when `ready`=1.
- `we`, in, 1: 1 = write, 0 = read; captured at accept.
- `addr`, in, ADDR_W: line address; captured at accept.
- `offset`, in, max(1,clog2(WORDS)): word select within the line for writes.
- `byte_en`, in, 4: byte lanes of `din` to write; bit i enables `din[8i+7:8i]`.
- `din`, in, 32: write data.
- `ready`, out, 1: the block can accept a request this cycle.
- `complete`, out, 1: one-cycle pulse; the access has finished.
- `dout`, out, 32*WORDS: full line from the last completed read; held otherwise.

## Operation
- Storage: array of 2**ADDR_W lines of 32*WORDS bits. Contents are not reset and are X until written.
- Accept: `req & ready` at a rising edge captures `we`, `addr`, `offset`, `byte_en` and `din` into holding registers. Inputs may change freely after the accept edge.
- FSM states:
  - IDLE: `ready`=1, `complete`=0. On accept, go to WAIT (cnt←0) if LATENCY≥1. If LATENCY=0, perform the access on the accept edge and go to RESP.
  - WAIT: `ready`=0, `complete`=0. cnt increments each edge. On the edge where cnt==LATENCY-1, perform the access and go to RESP.
  - RESP: `complete`=1, `ready`=1. On accept, behave exactly as an accept in IDLE (back-to-back). Otherwise go to IDLE.
- Write access: the captured word `offset` of line `addr` is updated only in lanes with `byte_en`=1. Other lanes and words are unchanged. `byte_en`=0000 completes normally with no change. `dout` is unchanged on writes.
- Read access: `dout` ← line `addr`, registered. It holds until the next read access.
- Ordering: a read accepted after a write completes returns the written data.
- Counter width is max(1,clog2(LATENCY+1)) bits. The counter never wraps, because WAIT exits at LATENCY-1.
- Reset at any point:
  - State returns to IDLE, cnt=0, `complete`=0, `dout`=0.
  - An in-flight write is dropped and memory is not modified.
  - `req` is ignored while `rst`=1.

## Timing
- Take the accept edge as edge E0 and the cycle before it as cycle 0.
- `complete` is high in cycle LATENCY+1 only. For LATENCY=20, cycles 1–20 are WAIT and cycle 21 is RESP.
- `dout` is valid from the start of the RESP cycle of a read.
- The memory write takes effect at the edge entering RESP.
- Back-to-back throughput is one access per LATENCY+1 cycles. With LATENCY=0, one access per cycle (`ready` stays 1).
- Reset values, first cycle after any edge with `rst`=1: `ready`=1, `complete`=0, `dout`=0.
- All outputs are decoded from registered state; there are no combinational paths from inputs to outputs.

## Test plan
- Basic write/read, LATENCY=20, WORDS=4:
  - Stimulus: write `din`=0xDEADBEEF, `addr`=5, `offset`=2, `byte_en`=1111; then read `addr`=5.
  - Required: `complete` pulses exactly 21 cycles after each accept edge's cycle 0; `dout[95:64]`=0xDEADBEEF.
- Byte enables:
  - Stimulus: write 0x11223344 to word 0 of line 3 with `byte_en`=1111; then write 0xAABBCCDD with `byte_en`=0101; then read line 3.
  - Required: `dout[31:0]`=0x11BB33DD; the other words are unchanged.
- Operand capture:
  - Stimulus: change `addr`, `din` and `we` on the cycle after accept, and hold `req`=1 through WAIT.
  - Required: the original operands are used; `ready`=0 during WAIT; the second request is accepted in the RESP cycle.
- LATENCY=0:
  - Stimulus: alternate write/read to lines 0–3 every cycle.
  - Required: `ready` stays 1; `complete`=1 every cycle after the first; read data matches the preceding writes.
- Reset mid-write, LATENCY=20:
  - Stimulus: issue a write to line 7, then assert `rst` in WAIT cycle 10.
  - Required: no `complete`; `dout`=0; `ready`=1 after reset; a read of line 7 returns its pre-write contents.
- Depth/wrap, ADDR_W=4:
  - Stimulus: write to lines 0 and 15, then read both.
  - Required: each line returns its own data, with no aliasing.
